// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// WRR_ARBITER_WEIGHT_EN selects weighted quotas; otherwise plain round-robin.
package wrr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } state_e;

    // Index width for n requesters, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/wrr_arbiter_rot_prio_enc.sv
// Circular priority encoder: first set request at or after ptr, wrapping at N.
module rot_prio_enc
    import wrr_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = cand;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with offer/accept handshake and completion pulse.
// Define WRR_ARBITER_WEIGHT_EN for per-requester quotas; default is plain round-robin.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned WW = 4,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_valid,
    input  logic            gnt_ready,
    input  logic            xfer_done,
    output logic            busy
);

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_found;

    logic          complete_c;
    logic          quota_done_c;
    logic [IW-1:0] next_ptr_c;

    rot_prio_enc #(
        .N  (N),
        .IW (IW)
    ) u_prio (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    assign complete_c = xfer_done &&
                        ((state_q == BUSY) || ((state_q == OFFER) && gnt_ready));

    assign next_ptr_c = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + IW'(1);

`ifdef WRR_ARBITER_WEIGHT_EN
    logic [N-1:0][WW-1:0] cnt_q, cnt_d;
    logic [WW-1:0]        wsel_c;
    logic [WW-1:0]        eff_c;

    // Quota of the current winner, sampled at the completion cycle
    always_comb begin
        wsel_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt_idx_q == IW'(i)) begin
                wsel_c = weight[i*WW +: WW];
            end
        end
    end

    assign eff_c        = (wsel_c == '0) ? WW'(1) : wsel_c;
    assign quota_done_c = (({1'b0, cnt_q[gnt_idx_q]} + (WW+1)'(1)) >= {1'b0, eff_c});
`else
    logic weight_unused_c;
    assign weight_unused_c = ^weight;
    assign quota_done_c    = 1'b1;
`endif

    // Next-state, grant and quota bookkeeping
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
`ifdef WRR_ARBITER_WEIGHT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d       = pick_onehot;
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = OFFER;
`ifdef WRR_ARBITER_WEIGHT_EN
                    if (pick_idx != ptr_q) begin
                        cnt_d[ptr_q] = '0;
                    end
`endif
                end
            end
            OFFER: begin
                if (gnt_ready) begin
                    gnt_valid_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                state_d = BUSY;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion overrides the per-state result
        if (complete_c) begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            busy_d      = 1'b0;
            if (quota_done_c) begin
                ptr_d = next_ptr_c;
`ifdef WRR_ARBITER_WEIGHT_EN
                cnt_d[gnt_idx_q] = '0;
`endif
            end else begin
                ptr_d = gnt_idx_q;
`ifdef WRR_ARBITER_WEIGHT_EN
                cnt_d[gnt_idx_q] = cnt_q[gnt_idx_q] + WW'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= '0;
`ifdef WRR_ARBITER_WEIGHT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
`ifdef WRR_ARBITER_WEIGHT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter; expected grant indices are queued ahead and popped per grant.
module tb_wrr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] weight;
    logic [3:0]  gnt;
    logic [1:0]  gnt_idx;
    logic        gnt_valid;
    logic        gnt_ready;
    logic        xfer_done;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    wrr_arbiter #(.N(4), .WW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .weight    (weight),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .gnt_ready (gnt_ready),
        .xfer_done (xfer_done),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_offer(input string tag);
        int k = 0;
        while (gnt_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_offer"}, 32'(gnt_valid), 32'd1);
    endtask

    // One full transaction: offer, accept, then completion one cycle later
    task automatic txn(input string tag);
        int e;
        wait_offer(tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
            e = 0;
        end else begin
            e = exp_q.pop_front();
        end
        chk({tag, "_idx"}, 32'(gnt_idx), 32'(e));
        chk({tag, "_gnt"}, 32'(gnt), 32'd1 << e);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        gnt_ready = 1'b1;
        tick();
        gnt_ready = 1'b0;
        chk({tag, "_acc_valid"}, 32'(gnt_valid), 32'd0);
        chk({tag, "_acc_gnt"}, 32'(gnt), 32'd1 << e);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_gnt"}, 32'(gnt), 32'd0);
    endtask

    task automatic do_reset(input string tag, input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk({tag, "_gnt"}, 32'(gnt), 32'd0);
            chk({tag, "_valid"}, 32'(gnt_valid), 32'd0);
            chk({tag, "_busy"}, 32'(busy), 32'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] pat [5];
        pat[0] = 4'b0000; pat[1] = 4'b0010; pat[2] = 4'b1000; pat[3] = 4'b0110; pat[4] = 4'b0000;

        rst       = 1'b1;
        req       = 4'b1111;
        weight    = 16'h2013;  // idx3=2, idx2=0, idx1=1, idx0=3
        gnt_ready = 1'b0;
        xfer_done = 1'b0;

        // Reset held with all requesting, then round sequence from idx 0
        do_reset("rst", 3);
`ifdef WRR_ARBITER_WEIGHT_EN
        exp_q = '{0, 0, 0, 1, 2, 3, 3, 0};
`else
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int i = 0; i < 8; i++) txn("seq");

        // Owner of idx0 drops out mid-quota; quota forfeited, pointer moves past idx1
        do_reset("rst2", 1);
        exp_q.push_back(0);
        txn("q0");
        req = 4'b0010;
        exp_q.push_back(1);
        txn("q1");
        req = 4'b1111;
`ifdef WRR_ARBITER_WEIGHT_EN
        exp_q = '{2, 3, 3, 0, 0, 0, 1};
`else
        exp_q = '{2, 3, 0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 7; i++) txn("fwd");

        // Held offer ignores req changes and stray completion pulses
        do_reset("rst3", 1);
        wait_offer("hold");
        chk("hold_idx0", 32'(gnt_idx), 32'd0);
        for (int i = 0; i < 5; i++) begin
            req       = pat[i];
            xfer_done = (i % 2 == 0);
            tick();
            chk("hold_gnt", 32'(gnt), 32'd1);
            chk("hold_idx", 32'(gnt_idx), 32'd0);
            chk("hold_valid", 32'(gnt_valid), 32'd1);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        // Accept and completion in the same cycle finish directly
        req       = 4'b0000;
        gnt_ready = 1'b1;
        xfer_done = 1'b1;
        tick();
        chk("same_valid", 32'(gnt_valid), 32'd0);
        chk("same_busy", 32'(busy), 32'd0);
        chk("same_gnt", 32'(gnt), 32'd0);
        // Handshake inputs in IDLE have no effect
        tick();
        gnt_ready = 1'b0;
        xfer_done = 1'b0;
        tick();
        chk("idle_valid", 32'(gnt_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        req = 4'b1111;
`ifdef WRR_ARBITER_WEIGHT_EN
        exp_q.push_back(0);
`else
        exp_q.push_back(1);
`endif
        txn("after_same");

        // Reset while busy on idx2 aborts the grant; restart from lowest requester
        do_reset("rst4", 1);
        req = 4'b0100;
        wait_offer("b2");
        chk("b2_gnt", 32'(gnt), 32'b0100);
        gnt_ready = 1'b1;
        tick();
        gnt_ready = 1'b0;
        chk("b2_busy", 32'(busy), 32'd1);
        chk("b2_valid", 32'(gnt_valid), 32'd0);
        rst = 1'b1;
        tick();
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(gnt_valid), 32'd0);
        rst = 1'b0;
        req = 4'b1010;
        exp_q.push_back(1);
        txn("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
